// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU: function codes and condition-code layout.
package y86_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Only ifun 0..3 name real operations; everything above is an illegal encoding.
  function automatic logic fun_is_legal(input logic [3:0] fun);
    return (fun <= ALU_XOR);
  endfunction

endpackage

// File: rtl/y86_alu_comb.sv
// Combinational Y86 ALU core: result, ZF/SF/OF flags and illegal-function decode.
module y86_alu_comb
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       fun_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output cc_t              flags_o,
  output logic             illegal_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic             ovf;

  // Operation select; Y86 subtract is b minus a, and illegal codes force a zero result.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (fun_i)
      ALU_ADD: begin
        res = b_i + a_i;
        ovf = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        res = b_i - a_i;
        ovf = (a_i[MSB] != b_i[MSB]) && (res[MSB] != b_i[MSB]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_XOR: res = a_i ^ b_i;
      default: res = '0;
    endcase
  end

  assign result_o   = res;
  assign flags_o.zf = (res == '0);
  assign flags_o.sf = res[MSB];
  assign flags_o.of = ovf;
  assign illegal_o  = !fun_is_legal(fun_i);

endmodule

// File: rtl/y86_alu_pipe.sv
// Registered Y86 ALU: one-deep output register behind a valid/ready handshake,
// plus the architectural condition-code register. WIDTH must be at least 2.
module y86_alu_pipe
  import y86_alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter bit CC_RST_ZF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam cc_t CcReset = '{zf: CC_RST_ZF, sf: 1'b0, of: 1'b0};

  logic [WIDTH-1:0] aluResult;
  cc_t              aluFlags;
  logic             aluIllegal;

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q,    err_d;
  cc_t              cc_q,     cc_d;

  logic accept;
  logic outTake;

  y86_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .fun_i     (in_fun),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (aluResult),
    .flags_o   (aluFlags),
    .illegal_o (aluIllegal)
  );

  // A single output slot: room exists when it is empty or being drained this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign outTake  = valid_q && out_ready;

  // Next-state for the output slot and CC; a new accept overrides a drain so throughput stays one per cycle.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    err_d    = err_q;
    cc_d     = cc_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = aluResult;
      err_d    = aluIllegal;
      if (in_set_cc && !aluIllegal) begin
        cc_d = aluFlags;
      end
    end else if (outTake) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any pending result and restores the Y86 default flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      cc_q     <= CcReset;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      err_q    <= err_d;
      cc_q     <= cc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_err    = err_q;
  assign cc_zf      = cc_q.zf;
  assign cc_sf      = cc_q.sf;
  assign cc_of      = cc_q.of;

endmodule
